// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes and pipeline bubble defaults.
// Used by the fetch stage and by the pipeline control logic.
package y86_pkg;

  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    STAT_AOK = 2'b00,
    STAT_HLT = 2'b01,
    STAT_ADR = 2'b10,
    STAT_INS = 2'b11
  } stat_e;

  localparam stat_e      BUBBLE_STAT  = STAT_AOK;
  localparam logic [3:0] BUBBLE_ICODE = I_NOP;
  localparam logic [3:0] BUBBLE_IFUN  = 4'h0;

  function automatic logic need_regids(input logic [3:0] icode);
    return (icode == I_CMOV)  || (icode == I_IRMOV) || (icode == I_RMMOV) ||
           (icode == I_MRMOV) || (icode == I_OPQ)   || (icode == I_PUSH)  ||
           (icode == I_POP);
  endfunction

  function automatic logic need_valc(input logic [3:0] icode);
    return (icode == I_IRMOV) || (icode == I_RMMOV) || (icode == I_MRMOV) ||
           (icode == I_JXX)   || (icode == I_CALL);
  endfunction

endpackage

// File: rtl/fetch_align.sv
// Combinational instruction split: icode/ifun, register ids, constant, valP,
// fetch status and the predicted next PC for the bytes presented at f_pc.
module fetch_align
  import y86_pkg::*;
#(
  parameter int PC_W = 64
) (
  input  logic [79:0]     imem_data,
  input  logic            imem_error,
  input  logic [PC_W-1:0] f_pc,
  output logic [3:0]      icode,
  output logic [3:0]      ifun,
  output logic [3:0]      rA,
  output logic [3:0]      rB,
  output logic [PC_W-1:0] valC,
  output logic [PC_W-1:0] valP,
  output logic [1:0]      f_stat,
  output logic [PC_W-1:0] f_predPC
);

  logic  regids;
  logic  has_valc;
  logic  instr_valid;
  stat_e stat;

  always_comb begin
    icode = imem_data[7:4];
    ifun  = imem_data[3:0];
    // A bad address must not look like a real instruction downstream.
    if (imem_error) begin
      icode = I_NOP;
      ifun  = 4'h0;
    end

    instr_valid = (icode <= I_POP);
    regids      = need_regids(icode);
    has_valc    = need_valc(icode);

    rA = RNONE;
    rB = RNONE;
    if (regids) begin
      rA = imem_data[15:12];
      rB = imem_data[11:8];
    end

    valC = '0;
    if (has_valc) begin
      valC = regids ? PC_W'(imem_data[79:16]) : PC_W'(imem_data[71:8]);
    end

    valP = f_pc + PC_W'(1) + PC_W'(regids) + (has_valc ? PC_W'(8) : PC_W'(0));

    f_predPC = ((icode == I_JXX) || (icode == I_CALL)) ? valC : valP;

    if (imem_error)        stat = STAT_ADR;
    else if (!instr_valid) stat = STAT_INS;
    else if (icode == I_HALT) stat = STAT_HLT;
    else                   stat = STAT_AOK;
    f_stat = stat;
  end

endmodule

// File: rtl/pipe_fetch.sv
// Y86-64 fetch stage with F and D pipeline registers; PC select lives here.
// Optional FETCH_PERF_CNT_EN adds a 32-bit count of non-bubble D loads.
module pipe_fetch
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          PC_W     = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            F_stall,
  input  logic            D_stall,
  input  logic            D_bubble,
  input  logic [3:0]      M_icode,
  input  logic            M_cnd,
  input  logic [PC_W-1:0] M_valA,
  input  logic [3:0]      W_icode,
  input  logic [PC_W-1:0] W_valM,
  input  logic [79:0]     imem_data,
  input  logic            imem_error,
  output logic [PC_W-1:0] f_pc,
  output logic [1:0]      D_stat,
  output logic [3:0]      D_icode,
  output logic [3:0]      D_ifun,
  output logic [3:0]      D_rA,
  output logic [3:0]      D_rB,
  output logic [PC_W-1:0] D_valC,
  output logic [PC_W-1:0] D_valP
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     fetch_count
`endif
);

  logic [PC_W-1:0] f_pred_pc_q, f_pred_pc_d;

  logic [1:0]      d_stat_q,  d_stat_d;
  logic [3:0]      d_icode_q, d_icode_d;
  logic [3:0]      d_ifun_q,  d_ifun_d;
  logic [3:0]      d_ra_q,    d_ra_d;
  logic [3:0]      d_rb_q,    d_rb_d;
  logic [PC_W-1:0] d_valc_q,  d_valc_d;
  logic [PC_W-1:0] d_valp_q,  d_valp_d;

  logic [3:0]      a_icode, a_ifun, a_ra, a_rb;
  logic [PC_W-1:0] a_valc, a_valp, a_pred_pc;
  logic [1:0]      a_stat;

  // Recovery overrides are not gated by F_stall; only the predictor update is.
  always_comb begin
    if ((M_icode == I_JXX) && !M_cnd) f_pc = M_valA;
    else if (W_icode == I_RET)        f_pc = W_valM;
    else                              f_pc = f_pred_pc_q;
  end

  fetch_align #(.PC_W(PC_W)) u_align (
    .imem_data  (imem_data),
    .imem_error (imem_error),
    .f_pc       (f_pc),
    .icode      (a_icode),
    .ifun       (a_ifun),
    .rA         (a_ra),
    .rB         (a_rb),
    .valC       (a_valc),
    .valP       (a_valp),
    .f_stat     (a_stat),
    .f_predPC   (a_pred_pc)
  );

  always_comb begin
    f_pred_pc_d = f_pred_pc_q;
    if (!F_stall) f_pred_pc_d = a_pred_pc;
  end

  // Stall outranks bubble so a held instruction is never lost.
  always_comb begin
    d_stat_d  = d_stat_q;
    d_icode_d = d_icode_q;
    d_ifun_d  = d_ifun_q;
    d_ra_d    = d_ra_q;
    d_rb_d    = d_rb_q;
    d_valc_d  = d_valc_q;
    d_valp_d  = d_valp_q;
    if (!D_stall) begin
      if (D_bubble) begin
        d_stat_d  = BUBBLE_STAT;
        d_icode_d = BUBBLE_ICODE;
        d_ifun_d  = BUBBLE_IFUN;
        d_ra_d    = RNONE;
        d_rb_d    = RNONE;
        d_valc_d  = '0;
        d_valp_d  = '0;
      end else begin
        d_stat_d  = a_stat;
        d_icode_d = a_icode;
        d_ifun_d  = a_ifun;
        d_ra_d    = a_ra;
        d_rb_d    = a_rb;
        d_valc_d  = a_valc;
        d_valp_d  = a_valp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_pred_pc_q <= PC_W'(RESET_PC);
      d_stat_q    <= BUBBLE_STAT;
      d_icode_q   <= BUBBLE_ICODE;
      d_ifun_q    <= BUBBLE_IFUN;
      d_ra_q      <= RNONE;
      d_rb_q      <= RNONE;
      d_valc_q    <= '0;
      d_valp_q    <= '0;
    end else begin
      f_pred_pc_q <= f_pred_pc_d;
      d_stat_q    <= d_stat_d;
      d_icode_q   <= d_icode_d;
      d_ifun_q    <= d_ifun_d;
      d_ra_q      <= d_ra_d;
      d_rb_q      <= d_rb_d;
      d_valc_q    <= d_valc_d;
      d_valp_q    <= d_valp_d;
    end
  end

  assign D_stat  = d_stat_q;
  assign D_icode = d_icode_q;
  assign D_ifun  = d_ifun_q;
  assign D_rA    = d_ra_q;
  assign D_rB    = d_rb_q;
  assign D_valC  = d_valc_q;
  assign D_valP  = d_valp_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (!D_stall && !D_bubble) fetch_count_d = fetch_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) fetch_count_q <= '0;
    else     fetch_count_q <= fetch_count_d;
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_pipe_fetch.sv
// Directed bench for pipe_fetch: PC select, split/classification, D register
// stall/bubble/reset behaviour and, when FETCH_PERF_CNT_EN is defined, fetch_count.
module tb_pipe_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        F_stall, D_stall, D_bubble;
  logic [3:0]  M_icode, W_icode;
  logic        M_cnd;
  logic [63:0] M_valA, W_valM;
  logic [79:0] imem_data;
  logic        imem_error;
  logic [63:0] f_pc;
  logic [1:0]  D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pipe_fetch #(.RESET_PC(64'h0), .PC_W(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .F_stall    (F_stall),
    .D_stall    (D_stall),
    .D_bubble   (D_bubble),
    .M_icode    (M_icode),
    .M_cnd      (M_cnd),
    .M_valA     (M_valA),
    .W_icode    (W_icode),
    .W_valM     (W_valM),
    .imem_data  (imem_data),
    .imem_error (imem_error),
    .f_pc       (f_pc),
    .D_stat     (D_stat),
    .D_icode    (D_icode),
    .D_ifun     (D_ifun),
    .D_rA       (D_rA),
    .D_rB       (D_rB),
    .D_valC     (D_valC),
    .D_valP     (D_valP)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100us");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
    M_icode = 4'h0; M_cnd = 1'b0; M_valA = '0;
    W_icode = 4'h0; W_valM = '0;
    imem_data = '0; imem_error = 1'b0;

    // reset state
    tick();
    chk("rst_icode", D_icode, 64'h1);
    chk("rst_stat",  D_stat,  64'h0);
    chk("rst_ra",    D_rA,    64'hF);
    chk("rst_rb",    D_rB,    64'hF);
    chk("rst_valc",  D_valC,  64'h0);
    chk("rst_valp",  D_valP,  64'h0);
    chk("rst_fpc",   f_pc,    64'h0);

    // irmovq $10, %rdx at 0
    rst = 1'b0;
    imem_data = {64'h0A, 8'hF2, 8'h30};
    #1 chk("irmov_fpc_pre", f_pc, 64'h0);
    tick();
    chk("irmov_icode", D_icode, 64'h3);
    chk("irmov_ifun",  D_ifun,  64'h0);
    chk("irmov_ra",    D_rA,    64'hF);
    chk("irmov_rb",    D_rB,    64'h2);
    chk("irmov_valc",  D_valC,  64'hA);
    chk("irmov_valp",  D_valP,  64'hA);
    chk("irmov_pred",  f_pc,    64'hA);

    // jmp 0x20 at 0xA
    imem_data = {8'h00, 64'h20, 8'h70};
    tick();
    chk("jmp_valp", D_valP, 64'h13);
    chk("jmp_valc", D_valC, 64'h20);
    chk("jmp_pred", f_pc,   64'h20);

    // jne 0x100 at 0x20, predicted taken
    imem_data = {8'h00, 64'h100, 8'h74};
    tick();
    chk("jne_ifun", D_ifun, 64'h4);
    chk("jne_valp", D_valP, 64'h29);
    chk("jne_pred", f_pc,   64'h100);

    // mispredict recovery, same cycle
    M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'h29;
    #1 chk("mispred_fpc", f_pc, 64'h29);
    M_cnd = 1'b1;
    #1 chk("taken_fpc", f_pc, 64'h100);
    M_cnd = 1'b0;
    imem_data = {72'h0, 8'h10};
    tick();
    chk("recov_icode", D_icode, 64'h1);
    chk("recov_valp",  D_valP,  64'h2A);
    M_icode = 4'h0;
    #1 chk("recov_pred", f_pc, 64'h2A);

    // ret override with F_stall high
    W_icode = 4'h9; W_valM = 64'h55; F_stall = 1'b1;
    imem_data = {72'h0, 8'h90};
    #1 chk("ret_fpc", f_pc, 64'h55);
    tick();
    chk("ret_icode", D_icode, 64'h9);
    chk("ret_valp",  D_valP,  64'h56);
    W_icode = 4'h0;
    #1 chk("ret_fstall_hold", f_pc, 64'h2A);
    M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'h77; W_icode = 4'h9;
    #1 chk("m_over_w", f_pc, 64'h77);
    M_icode = 4'h0; W_icode = 4'h0; F_stall = 1'b0;

    // mrmovq 8(%rdx), %rcx at 0x2A
    imem_data = {64'h8, 8'h12, 8'h50};
    tick();
    chk("mrmov_icode", D_icode, 64'h5);
    chk("mrmov_ra",    D_rA,    64'h1);
    chk("mrmov_rb",    D_rB,    64'h2);
    chk("mrmov_valc",  D_valC,  64'h8);
    chk("mrmov_valp",  D_valP,  64'h34);
    chk("mrmov_pred",  f_pc,    64'h34);

    // D stall two cycles (second with bubble too), then bubble
    D_stall = 1'b1; F_stall = 1'b1;
    imem_data = {64'h0, 8'h01, 8'h60};
    tick();
    chk("stall1_icode", D_icode, 64'h5);
    chk("stall1_valp",  D_valP,  64'h34);
    chk("stall1_ra",    D_rA,    64'h1);
    D_bubble = 1'b1;
    tick();
    chk("stall2_icode", D_icode, 64'h5);
    chk("stall2_valc",  D_valC,  64'h8);
    D_stall = 1'b0;
    tick();
    chk("bubble_icode", D_icode, 64'h1);
    chk("bubble_stat",  D_stat,  64'h0);
    chk("bubble_ra",    D_rA,    64'hF);
    chk("bubble_valp",  D_valP,  64'h0);
    chk("bubble_fpc",   f_pc,    64'h34);
    F_stall = 1'b0; D_bubble = 1'b0;

    // imem_error forces NOP/ifun 0 and ADR
    imem_error = 1'b1;
    imem_data = {64'h0, 8'h01, 8'h61};
    tick();
    chk("adr_stat",  D_stat,  64'h2);
    chk("adr_icode", D_icode, 64'h1);
    chk("adr_ifun",  D_ifun,  64'h0);
    chk("adr_ra",    D_rA,    64'hF);
    chk("adr_pred",  f_pc,    64'h35);
    imem_error = 1'b0;

    imem_data = {72'h0, 8'hC0};
    tick();
    chk("ins_stat",  D_stat,  64'h3);
    chk("ins_icode", D_icode, 64'hC);
    chk("ins_valp",  D_valP,  64'h36);

    imem_data = {72'h0, 8'h00};
    tick();
    chk("hlt_stat",  D_stat,  64'h1);
    chk("hlt_icode", D_icode, 64'h0);
    chk("hlt_valp",  D_valP,  64'h37);

    // call to near top of address space, then valP wraps
    imem_data = {8'h00, 64'hFFFF_FFFF_FFFF_FFFC, 8'h80};
    tick();
    chk("call_icode", D_icode, 64'h8);
    chk("call_valc",  D_valC,  64'hFFFF_FFFF_FFFF_FFFC);
    chk("call_valp",  D_valP,  64'h40);
    chk("call_pred",  f_pc,    64'hFFFF_FFFF_FFFF_FFFC);
    imem_data = {64'h0123, 8'hF3, 8'h30};
    tick();
    chk("wrap_valp", D_valP, 64'h6);
    chk("wrap_rb",   D_rB,   64'h3);
    chk("wrap_pred", f_pc,   64'h6);

    // OPq: regids but no constant even with nonzero trailing bytes
    imem_data = {64'hDEAD_BEEF_0000_0000, 8'h23, 8'h60};
    tick();
    chk("opq_valc", D_valC, 64'h0);
    chk("opq_ra",   D_rA,   64'h2);
    chk("opq_rb",   D_rB,   64'h3);
    chk("opq_valp", D_valP, 64'h8);
    chk("opq_stat", D_stat, 64'h0);

    // mid-stream reset
    rst = 1'b1;
    tick();
    chk("mrst_icode", D_icode, 64'h1);
    chk("mrst_valp",  D_valP,  64'h0);
    chk("mrst_rb",    D_rB,    64'hF);
    chk("mrst_fpc",   f_pc,    64'h0);
    rst = 1'b0;

`ifdef FETCH_PERF_CNT_EN
    chk("cnt_rst", fetch_count, 64'h0);
    imem_data = {72'h0, 8'h10};
    for (int i = 0; i < 3; i++) tick();
    chk("cnt_3", fetch_count, 64'h3);
    D_stall = 1'b1;
    tick();
    D_stall = 1'b0; D_bubble = 1'b1;
    tick();
    D_bubble = 1'b0;
    chk("cnt_stall_bubble", fetch_count, 64'h3);
    imem_data = {64'h0, 8'h23, 8'h60};
    tick();
    chk("cnt_4", fetch_count, 64'h4);
    chk("cnt_opq_icode", D_icode, 64'h6);
    rst = 1'b1;
    tick();
    chk("cnt_mrst", fetch_count, 64'h0);
    chk("cnt_mrst_icode", D_icode, 64'h1);
    rst = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
